// File: rtl/cfg_arb_pkg.sv
// cfg_arb_pkg: shared constants, FSM state type and counter helper for the cfg arbiter.
//   OP_READ / OP_WRITE : encoding of the cfg op bit
//   state_e            : arbiter FSM states
//   CNT_W              : width of each per-requester grant counter (stats build only)
//   sat_inc            : saturating increment used by the grant counters
package cfg_arb_pkg;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;
   localparam int   CNT_W    = 16;

   typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cfg_arb_rr_pick.sv
// cfg_arb_rr_pick: combinational round-robin picker.
//   elig   in  NUM_REQ  eligible requesters
//   rr_ptr in  PTR_W    highest-priority index this round
//   found  out 1        at least one requester is eligible
//   gnt    out PTR_W    first eligible index searching upward from rr_ptr, mod NUM_REQ
module cfg_arb_rr_pick
   import cfg_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int PTR_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic               found,
   output logic [PTR_W-1:0]   gnt
);

   localparam int SW = PTR_W + 1;

   logic [SW-1:0] idx;

   // Walk from the farthest candidate back towards rr_ptr so the closest
   // eligible index is the last (winning) assignment.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + SW'(k);
         if (idx >= SW'(NUM_REQ)) idx = idx - SW'(NUM_REQ);
         if (elig[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            gnt   = idx[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cfg_arbiter.sv
// cfg_arbiter: shares one en/rdy cfg port between NUM_REQ requesters.
// Each requester has a 1-entry request buffer and a 1-entry read-response buffer;
// buffered requests are issued round-robin, one cfg transaction per ISSUE visit.
// Optional feature macro: CFG_ARB_STATS_EN adds grant_cnt (16-bit saturating
// per-requester count of fired cfg transactions).
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   req_address/data_in/op/en   per-requester request (slice i = [i*W +: W])
//   req_rdy                     request buffer i empty
//   rsp_en / rsp_data / rsp_rdy per-requester response dequeue / data / full
//   cfg_address/data_in/op/en   to DUT cfg method; cfg_data_out/cfg_rdy from DUT
//   grant_cnt                   (CFG_ARB_STATS_EN only) NUM_REQ x 16-bit grant counters
module cfg_arbiter
   import cfg_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
   input  logic [NUM_REQ-1:0]        req_op,
   input  logic [NUM_REQ-1:0]        req_en,
   output logic [NUM_REQ-1:0]        req_rdy,
   input  logic [NUM_REQ-1:0]        rsp_en,
   output logic [NUM_REQ*DATA_W-1:0] rsp_data,
   output logic [NUM_REQ-1:0]        rsp_rdy,
   output logic [ADDR_W-1:0]         cfg_address,
   output logic [DATA_W-1:0]         cfg_data_in,
   output logic                      cfg_op,
   output logic                      cfg_en,
   input  logic [DATA_W-1:0]         cfg_data_out,
   input  logic                      cfg_rdy
`ifdef CFG_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             req_full, req_op_q, rsp_full, elig;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_q;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data_q, rsp_data_q;

   state_e           state, state_nxt;
   logic [PTR_W-1:0] gnt_q, rr_ptr, pick_gnt;
   logic             pick_found, launch;

   assign req_rdy  = ~req_full;
   assign rsp_rdy  = rsp_full;
   assign rsp_data = rsp_data_q;

   // A read may only issue into an empty response slot; a slot being dequeued
   // this very cycle counts as empty.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = req_full[i] && (req_op_q[i] == OP_WRITE || !rsp_full[i] || rsp_en[i]);
   end

   cfg_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .elig   (elig),
      .rr_ptr (rr_ptr),
      .found  (pick_found),
      .gnt    (pick_gnt)
   );

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state / outputs
   always_comb begin
      state_nxt = state;
      cfg_en    = 1'b0;
      launch    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               launch    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cfg_en = cfg_rdy;
            if (cfg_rdy) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant and cfg output registers; cfg_* hold steady for the whole ISSUE stall.
   always_ff @(posedge CLK) begin
      if (RST) begin
         gnt_q       <= '0;
         rr_ptr      <= '0;
         cfg_address <= '0;
         cfg_data_in <= '0;
         cfg_op      <= 1'b0;
      end else begin
         if (launch) begin
            gnt_q       <= pick_gnt;
            cfg_address <= req_addr_q[pick_gnt];
            cfg_data_in <= req_data_q[pick_gnt];
            cfg_op      <= req_op_q[pick_gnt];
         end
         if (cfg_en)
            rr_ptr <= (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
      end
   end

   // Request and response buffers. A request slot is full while its transaction
   // is pending, so capture and fire never hit the same slot in one cycle; the
   // response slot of the granted requester is empty at fire time for the same reason.
   always_ff @(posedge CLK) begin
      if (RST) begin
         req_full   <= '0;
         req_op_q   <= '0;
         req_addr_q <= '0;
         req_data_q <= '0;
         rsp_full   <= '0;
         rsp_data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_en[i] && !req_full[i]) begin
               req_full[i]   <= 1'b1;
               req_op_q[i]   <= req_op[i];
               req_addr_q[i] <= req_address[i*ADDR_W +: ADDR_W];
               req_data_q[i] <= req_data_in[i*DATA_W +: DATA_W];
            end else if (cfg_en && gnt_q == PTR_W'(i)) begin
               req_full[i] <= 1'b0;
            end

            if (cfg_en && gnt_q == PTR_W'(i) && cfg_op == OP_READ) begin
               rsp_full[i]   <= 1'b1;
               rsp_data_q[i] <= cfg_data_out;
            end else if (rsp_en[i] && rsp_full[i]) begin
               rsp_full[i] <= 1'b0;
            end
         end
      end
   end

`ifdef CFG_ARB_STATS_EN
   logic [CNT_W-1:0] grant_q [NUM_REQ];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_REQ; i++) grant_q[i] <= '0;
      end else if (cfg_en) begin
         grant_q[gnt_q] <= sat_inc(grant_q[gnt_q]);
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_cnt[g*CNT_W +: CNT_W] = grant_q[g];
   end
`endif

endmodule
